// File: rtl/clk_period_meter_pkg.sv
// clk_period_meter_pkg: FSM state encoding and default sizing shared by the
// clk_period_meter files.
package clk_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  localparam int DEF_CNT_W = 32;
  localparam logic [DEF_CNT_W-1:0] DEF_TIMEOUT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: control and result bundle of the period meter.
// The master side drives the signal under test and requests; the slave is the meter.
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             meas_in;
  logic             start;
  logic             cont;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period_cnt;

  modport master (
    output meas_in, start, cont,
    input  busy, done, err, high_cnt, low_cnt, period_cnt
  );

  modport slave (
    input  meas_in, start, cont,
    output busy, done, err, high_cnt, low_cnt, period_cnt
  );
endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus one history register, giving the
// synchronized level and single-cycle rise/fall strobes.
module sync_edge_det (
  input  logic clk,
  input  logic clr,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronizer chain and edge-history register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures high time, low time and period of a slow async signal
// in clk cycles. Optional timeout abort is compiled in with CLK_PERIOD_METER_TIMEOUT_EN.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(DEF_TIMEOUT)
) (
  input logic               clk,
  input logic               clr,
  clk_period_meter_if.slave io
);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
`ifdef CLK_PERIOD_METER_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
  logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
  logic [CNT_W:0]   per_q, per_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             rise_s, fall_s, sync_level_unused, timeout_hit_s;

  sync_edge_det u_sync (
    .clk     (clk),
    .clr     (clr),
    .sig_i   (io.meas_in),
    .level_o (sync_level_unused),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  // The ARM wait reuses cnt, so one compare covers every waiting/counting state
  assign timeout_hit_s = TO_EN & (cnt_q >= TIMEOUT);

  // State and result registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      hold_q  <= CNT_ZERO;
      high_q  <= CNT_ZERO;
      low_q   <= CNT_ZERO;
      per_q   <= {(CNT_W+1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      high_q  <= high_d;
      low_q   <= low_d;
      per_q   <= per_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and measurement datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    high_d  = high_q;
    low_d   = low_q;
    per_d   = per_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start && !busy_q) begin
          state_d = ARM;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ARM: begin
        if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rise_s) begin
          cnt_d   = CNT_ONE;
          state_d = HIGH;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HIGH: begin
        if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (fall_s) begin
          hold_d  = cnt_q;
          cnt_d   = CNT_ONE;
          state_d = LOW;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      LOW: begin
        if (timeout_hit_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rise_s) begin
          high_d = hold_q;
          low_d  = cnt_q;
          per_d  = {1'b0, hold_q} + {1'b0, cnt_q};
          done_d = 1'b1;
          cnt_d  = CNT_ONE;
          if (io.cont) begin
            state_d = HIGH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    // busy covers the done cycle so a start arriving with the result is still ignored
    busy_d = (state_d != IDLE) || done_d;
  end

  assign io.busy       = busy_q;
  assign io.done       = done_q;
  assign io.err        = err_q;
  assign io.high_cnt   = high_q;
  assign io.low_cnt    = low_q;
  assign io.period_cnt = per_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: table-driven and hand-sequenced checks of clk_period_meter,
// with scoreboard queues popped on each done pulse.
module tb_clk_period_meter;
  import clk_period_meter_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [32:0] per;
  } exp_t;

  typedef struct {
    int          hi_t;
    int          lo_t;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [32:0] e_per;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(32)) io ();
  clk_period_meter_if #(.CNT_W(4))  io4 ();

  clk_period_meter #(.CNT_W(32)) u_dut (.clk(clk), .clr(clr), .io(io));
  clk_period_meter #(.CNT_W(4))  u_dut4 (.clk(clk), .clr(clr), .io(io4));

`ifdef CLK_PERIOD_METER_TIMEOUT_EN
  clk_period_meter_if #(.CNT_W(32)) io_t ();
  clk_period_meter #(.CNT_W(32), .TIMEOUT(32'd100)) u_dut_t (.clk(clk), .clr(clr), .io(io_t));
`endif

  exp_t sb_q[$];
  exp_t sb4_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   chk_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_meas(input logic b);
    io.meas_in  = b;
    io4.meas_in = b;
`ifdef CLK_PERIOD_METER_TIMEOUT_EN
    io_t.meas_in = b;
`endif
  endtask

  task automatic pulse_start(input logic s32, input logic s4);
    io.start  = s32;
    io4.start = s4;
    tick(1);
    io.start  = 1'b0;
    io4.start = 1'b0;
  endtask

  // opening rise, hi cycles high, lo cycles low, closing rise held 2 cycles
  task automatic wave(input int hi, input int lo);
    set_meas(1'b1);
    tick(hi);
    set_meas(1'b0);
    tick(lo);
    set_meas(1'b1);
    tick(2);
    set_meas(1'b0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || sb4_q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    chk("sb_drained", 64'(sb_q.size() + sb4_q.size()), 64'd0);
    sb_q.delete();
    sb4_q.delete();
  endtask

  // Scoreboard checker for the 32-bit meter
  always @(negedge clk) begin : mon32
    exp_t e;
    if (io.done) begin
      if (sb_q.size() == 0) begin
        chk("done_expected", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        chk("high_cnt", 64'(io.high_cnt), 64'(e.hi));
        chk("low_cnt", 64'(io.low_cnt), 64'(e.lo));
        chk("period_cnt", 64'(io.period_cnt), 64'(e.per));
        chk("err_at_done", 64'(io.err), 64'd0);
      end
      if (chk_gap && last_done >= 0) chk("done_gap", 64'(cyc - last_done), 64'd5);
      last_done = cyc;
    end
  end

  // Scoreboard checker for the 4-bit meter
  always @(negedge clk) begin : mon4
    exp_t e;
    if (io4.done) begin
      if (sb4_q.size() == 0) begin
        chk("done4_expected", 64'(sb4_q.size()), 64'd1);
      end else begin
        e = sb4_q.pop_front();
        chk("high_cnt4", 64'(io4.high_cnt), 64'(e.hi));
        chk("low_cnt4", 64'(io4.low_cnt), 64'(e.lo));
        chk("period_cnt4", 64'(io4.period_cnt), 64'(e.per));
        chk("err4_at_done", 64'(io4.err), 64'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   k;
    vt[0] = '{hi_t: 1,   lo_t: 1,  e_hi: 32'd1,   e_lo: 32'd1,  e_per: 33'd2};
    vt[1] = '{hi_t: 2,   lo_t: 9,  e_hi: 32'd2,   e_lo: 32'd9,  e_per: 33'd11};
    vt[2] = '{hi_t: 7,   lo_t: 3,  e_hi: 32'd7,   e_lo: 32'd3,  e_per: 33'd10};
    vt[3] = '{hi_t: 100, lo_t: 1,  e_hi: 32'd100, e_lo: 32'd1,  e_per: 33'd101};
    vt[4] = '{hi_t: 13,  lo_t: 64, e_hi: 32'd13,  e_lo: 32'd64, e_per: 33'd77};

    io.start = 1'b0;
    io.cont = 1'b0;
    io4.start = 1'b0;
    io4.cont = 1'b0;
`ifdef CLK_PERIOD_METER_TIMEOUT_EN
    io_t.start = 1'b0;
    io_t.cont = 1'b0;
`endif
    set_meas(1'b0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(io.busy), 64'd0);
    chk("rst_done", 64'(io.done), 64'd0);
    chk("rst_err", 64'(io.err), 64'd0);
    chk("rst_high", 64'(io.high_cnt), 64'd0);
    chk("rst_low", 64'(io.low_cnt), 64'd0);
    chk("rst_period", 64'(io.period_cnt), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    tick(2);

    // 30/20 with done latency and busy timing
    sb_q.push_back('{32'd30, 32'd20, 33'd50});
    pulse_start(1'b1, 1'b0);
    chk("busy_after_start", 64'(io.busy), 64'd1);
    set_meas(1'b1);
    tick(30);
    set_meas(1'b0);
    tick(20);
    set_meas(1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("done_early", 64'(io.done), 64'd0);
    @(negedge clk);
    chk("done_3rd_edge", 64'(io.done), 64'd1);
    chk("busy_at_done", 64'(io.busy), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(io.done), 64'd0);
    chk("busy_after_done", 64'(io.busy), 64'd0);
    @(posedge clk);
    #1;
    set_meas(1'b0);
    drain(10);
    tick(3);

    // table of single measurements
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{vt[i].e_hi, vt[i].e_lo, vt[i].e_per});
      pulse_start(1'b1, 1'b0);
      wave(vt[i].hi_t, vt[i].lo_t);
      drain(20);
      tick(3);
    end

    // start while meas_in already high: the partial pulse is not counted
    set_meas(1'b1);
    tick(4);
    sb_q.push_back('{32'd30, 32'd20, 33'd50});
    pulse_start(1'b1, 1'b0);
    tick(6);
    set_meas(1'b0);
    tick(7);
    wave(30, 20);
    drain(20);
    tick(3);

    // continuous mode fed by a divide-by-5 (3 high / 2 low)
    io.cont = 1'b1;
    last_done = -1;
    chk_gap = 1'b1;
    pulse_start(1'b1, 1'b0);
    for (int p = 0; p < 8; p++) begin
      sb_q.push_back('{32'd3, 32'd2, 33'd5});
      set_meas(1'b1);
      tick(3);
      set_meas(1'b0);
      tick(2);
    end
    io.cont = 1'b0;
    set_meas(1'b1);
    tick(2);
    set_meas(1'b0);
    drain(20);
    chk_gap = 1'b0;
    tick(2);
    chk("busy_after_cont", 64'(io.busy), 64'd0);

`ifndef CLK_PERIOD_METER_TIMEOUT_EN
    // 4-bit counter saturation against the 32-bit reference
    sb_q.push_back('{32'd40, 32'd10, 33'd50});
    sb4_q.push_back('{32'd15, 32'd10, 33'd25});
    pulse_start(1'b1, 1'b1);
    wave(40, 10);
    drain(20);
    tick(3);
`else
    // timeout: one good result, then meas_in stuck high
    io_t.start = 1'b1;
    tick(1);
    io_t.start = 1'b0;
    wave(5, 5);
    k = 0;
    while (!io_t.done && k < 50) begin @(negedge clk); k++; end
    chk("t_done", 64'(io_t.done), 64'd1);
    chk("t_high", 64'(io_t.high_cnt), 64'd5);
    tick(3);
    io_t.start = 1'b1;
    tick(1);
    io_t.start = 1'b0;
    set_meas(1'b1);
    k = 0;
    while (!io_t.err && k < 300) begin @(negedge clk); k++; end
    chk("t_err", 64'(io_t.err), 64'd1);
    chk("t_busy", 64'(io_t.busy), 64'd0);
    chk("t_keep_high", 64'(io_t.high_cnt), 64'd5);
    chk("t_keep_period", 64'(io_t.period_cnt), 64'd10);
    @(posedge clk);
    #1;
    set_meas(1'b0);
    tick(3);
`endif

    // asynchronous clear mid-HIGH
    pulse_start(1'b1, 1'b1);
    set_meas(1'b1);
    tick(10);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_busy", 64'(io.busy), 64'd0);
    chk("clr_done", 64'(io.done), 64'd0);
    chk("clr_high", 64'(io.high_cnt), 64'd0);
    chk("clr_low", 64'(io.low_cnt), 64'd0);
    chk("clr_period", 64'(io.period_cnt), 64'd0);
    chk("clr_high4", 64'(io4.high_cnt), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    set_meas(1'b0);
    tick(5);
    set_meas(1'b1);
    tick(3);
    set_meas(1'b0);
    tick(8);
    chk("busy_post_clr", 64'(io.busy), 64'd0);
    sb_q.push_back('{32'd12, 32'd8, 33'd20});
    pulse_start(1'b1, 1'b0);
    wave(12, 8);
    drain(20);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the high time, low time and period of a slow, asynchronous clock-like signal, such as the output of the odd/even frequency dividers, in units of the fast system clock. It sits directly downstream of a divider stage. It lets firmware or a self-check bench confirm a divided clock's period and duty without an oscilloscope. Results are registered and announced with a one-cycle done pulse.

## Interface

**Parameters**
- CNT_W, 32: width of high/low counters; period output is CNT_W+1 bits.
- TIMEOUT, 2^CNT_W-1: clk cycles allowed in any wait/count state before error (used only with timeout feature).

**Ports**
- clk  in  1  system clock, rising-edge.
- clr  in  1  reset: asynchronous, active-low.
- meas_in  in  1  signal under measurement, asynchronous to clk.
- start  in  1  one-cycle request to begin a measurement; ignored while busy.
- cont  in  1  continuous mode: re-measure back-to-back without a new start.
- busy  out  1  high from accepted start until done/err/abort.
- done  out  1  one-cycle pulse: high_cnt/low_cnt/period_cnt updated this cycle.
- err  out  1  one-cycle pulse: timeout fired; result registers unchanged.
- high_cnt  out  CNT_W  clk cycles meas_in was high.
- low_cnt  out  CNT_W  clk cycles meas_in was low.
- period_cnt  out  CNT_W+1  high_cnt+low_cnt.

## Operation

- meas_in passes through a 2-FF synchronizer, then an edge detector with one more register. rise/fall are single-cycle strobes.
- States: IDLE, ARM, HIGH, LOW.
- IDLE: start=1 -> ARM, busy=1.
- ARM: wait for rise. On rise: cnt<=1, -> HIGH. A measurement never starts mid-pulse.
- HIGH: on fall: hold<=cnt, cnt<=1, -> LOW. Otherwise cnt<=cnt+1.
- LOW: on rise: high_cnt<=hold, low_cnt<=cnt, period_cnt<=hold+cnt (CNT_W+1-bit add, no overflow), done=1.
  - If cont=1: cnt<=1, stay measuring in HIGH.
  - If cont=0: -> IDLE, busy=0.
  - Otherwise cnt<=cnt+1.
- Counter saturates at 2^CNT_W-1; it never wraps.
- start while busy: ignored. cont sampled only at the LOW->exit decision.
- cont dropped mid-measurement: current measurement completes, then IDLE.
- Simultaneous rise and fall cannot occur (single synchronized bit).
- A pulse shorter than 1 clk may be missed. Any resulting count is still the synchronized view.
- Outputs hold their last value until the next done or reset.

## Timing

- Reset (clr=0, any time, including mid-measurement): state IDLE, busy=0, done=0, err=0, all counts 0, synchronizer and counter 0. Takes effect immediately; no partial result is published.
- Input edge to strobe: 3 clk rising edges (2 sync + edge reg). Applies equally to both edges, so counts are exact for edges aligned to clk and ±1 otherwise.
- done asserts on the 3rd clk edge after the closing rising edge of meas_in, for exactly 1 cycle.
- busy rises the cycle after start is sampled.

## Configuration

- CLK_PERIOD_METER_TIMEOUT_EN defined:
  - In ARM, HIGH and LOW, if cnt reaches TIMEOUT, or ARM wait cycles reach TIMEOUT, then err pulses for 1 cycle, the state goes to IDLE and busy=0.
  - Result registers are untouched.
  - cont does not re-arm after an error.
- Not defined: no timeout logic; err tied 0; the FSM waits indefinitely. Counters still saturate.

## Structure

- Package clk_period_meter_pkg holds:
  - state enum typedef (IDLE, ARM, HIGH, LOW);
  - default CNT_W constant;
  - default TIMEOUT constant.
- One sub-module, sync_edge_det: 2-FF synchronizer plus edge register. Outputs level, rise, fall. Reset to 0 on clr.

## Test plan

- meas_in high 30 / low 20 clk, edges aligned to clk, start, cont=0 -> one done: high_cnt=30, low_cnt=20, period_cnt=50; done 3 edges after the 2nd rise; busy falls next cycle.
- Divider N=5 feeding meas_in at 1 clk per divider input tick, cont=1 -> done every 5 cycles. In steady state high_cnt+low_cnt=5 every time, matching the divider duty.
- start asserted while meas_in already high -> no counting until the next rise; first result is correct (high 30/low 20).
- clr pulsed low mid-HIGH -> all outputs 0 immediately; no done; a new start measures correctly.
- With CLK_PERIOD_METER_TIMEOUT_EN, TIMEOUT=100, meas_in stuck high after rise -> err pulse at cnt=100; state IDLE; previous results retained.
- Without the macro, CNT_W=4, high time 40 -> high_cnt saturates at 15, period_cnt=15+low_cnt; no wrap, err=0.
